// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads program memory and
// issues latched instruction words to decode over a valid/ready handshake.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start, start_addr    begin fetching at start_addr (only from IDLE/HALT)
//   step_mode, step      pause after each accepted instruction / release one
//   mem_addr, mem_data   combinational program-memory read port (mem_addr = pc)
//   instr, instr_pc      latched instruction word and its fetch address
//   instr_valid          instr/instr_pc valid for decode
//   instr_ready          decode accepts instr this cycle
//   jump_en, jump_addr   on acceptance, redirect the next fetch to jump_addr
//   busy, halted         status: FETCH/ISSUE/STEP_WAIT, and HALT
module fetch_sequencer #(
    parameter int             AB      = 11,
    parameter int             DB      = 16,
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] HLT_OPC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AB-1:0] start_addr,
    input  logic          step_mode,
    input  logic          step,
    output logic [AB-1:0] mem_addr,
    input  logic [DB-1:0] mem_data,
    output logic [DB-1:0] instr,
    output logic [AB-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          jump_en,
    input  logic [AB-1:0] jump_addr,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_STEP_WAIT,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AB-1:0] pc_q, pc_d;
    logic [DB-1:0] instr_q, instr_d;
    logic [AB-1:0] instr_pc_q, instr_pc_d;

    logic           accept;
    logic           is_hlt;
    logic [OPW-1:0] opcode;

    assign opcode = instr_q[DB-1 -: OPW];
    assign is_hlt = (opcode == HLT_OPC);
    assign accept = (state_q == S_ISSUE) && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // memory is combinational: mem_data already reflects pc_q
                instr_d    = mem_data;
                instr_pc_d = pc_q;
                pc_d       = pc_q + AB'(1);
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    // a halt word wins over any jump offered with it
                    if (is_hlt) begin
                        state_d = S_HALT;
                    end else begin
                        if (jump_en) begin
                            pc_d = jump_addr;
                        end
                        state_d = step_mode ? S_STEP_WAIT : S_FETCH;
                    end
                end
            end
            S_STEP_WAIT: begin
                if (step || !step_mode) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = start_addr;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign busy        = (state_q == S_FETCH) ||
                         (state_q == S_ISSUE) ||
                         (state_q == S_STEP_WAIT);
    assign halted      = (state_q == S_HALT);

endmodule
